// File: rtl/parking_gate_controller.sv
// Parking lot gate sequencer: owns the slot-occupancy map, grants first-fit entry
// and named-slot exit, and holds the matching gate open for a fixed window.
module parking_gate_controller #(
   parameter int unsigned N_SLOTS     = 8,
   parameter int unsigned IDX_W       = 3,
   parameter int unsigned GATE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               entry_req,
   input  logic               exit_req,
   input  logic [IDX_W-1:0]   exit_slot,
   output logic               entry_ack,
   output logic [IDX_W-1:0]   assigned_slot,
   output logic               exit_ack,
   output logic               exit_err,
   output logic               gate_in_open,
   output logic               gate_out_open,
   output logic [N_SLOTS-1:0] free_map,
   output logic [IDX_W:0]     free_count,
   output logic               full
);

   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [N_SLOTS-1:0] map_d;
   logic [CNT_W-1:0]   count_d;
   logic [IDX_W-1:0]   slot_d;
   logic               full_d;
   logic               entry_ack_d, exit_ack_d, exit_err_d;
   logic               gate_in_d, gate_out_d;

   logic [N_SLOTS-1:0] alloc_mask;
   logic [IDX_W-1:0]   alloc_idx;
   logic               alloc_found;
   logic [N_SLOTS-1:0] exit_mask;
   logic               exit_in_range;
   logic               exit_slot_free;

   // State and output registers; reset closes any open gate immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         free_map      <= '1;
         free_count    <= CNT_W'(N_SLOTS);
         full          <= 1'b0;
         assigned_slot <= '0;
         entry_ack     <= 1'b0;
         exit_ack      <= 1'b0;
         exit_err      <= 1'b0;
         gate_in_open  <= 1'b0;
         gate_out_open <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         free_map      <= map_d;
         free_count    <= count_d;
         full          <= full_d;
         assigned_slot <= slot_d;
         entry_ack     <= entry_ack_d;
         exit_ack      <= exit_ack_d;
         exit_err      <= exit_err_d;
         gate_in_open  <= gate_in_d;
         gate_out_open <= gate_out_d;
      end
   end

   // First-fit search (slot 0 lives in the MSB) and exit-slot decode.
   always_comb begin
      alloc_mask     = '0;
      alloc_idx      = '0;
      alloc_found    = 1'b0;
      exit_mask      = '0;
      exit_in_range  = 1'b0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         if (!alloc_found && free_map[N_SLOTS-1-i]) begin
            alloc_found             = 1'b1;
            alloc_idx               = IDX_W'(i);
            alloc_mask[N_SLOTS-1-i] = 1'b1;
         end
         if (exit_slot == IDX_W'(i)) begin
            exit_in_range          = 1'b1;
            exit_mask[N_SLOTS-1-i] = 1'b1;
         end
      end
      exit_slot_free = |(free_map & exit_mask);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      map_d       = free_map;
      count_d     = free_count;
      slot_d      = assigned_slot;
      entry_ack_d = 1'b0;
      exit_ack_d  = 1'b0;
      exit_err_d  = 1'b0;
      gate_in_d   = gate_in_open;
      gate_out_d  = gate_out_open;

      case (state_q)
         IDLE: begin
            if (exit_req) begin
               exit_ack_d = 1'b1;
               if (exit_in_range && !exit_slot_free) begin
                  map_d      = free_map | exit_mask;
                  count_d    = free_count + CNT_W'(1);
                  gate_out_d = 1'b1;
                  timer_d    = TMR_W'(GATE_CYCLES - 1);
                  state_d    = EXIT_OPEN;
               end else begin
                  exit_err_d = 1'b1;
               end
            end else if (entry_req && !full && alloc_found) begin
               map_d       = free_map & ~alloc_mask;
               count_d     = free_count - CNT_W'(1);
               slot_d      = alloc_idx;
               entry_ack_d = 1'b1;
               gate_in_d   = 1'b1;
               timer_d     = TMR_W'(GATE_CYCLES - 1);
               state_d     = ENTRY_OPEN;
            end
         end
         ENTRY_OPEN, EXIT_OPEN: begin
            if (timer_q == '0) begin
               gate_in_d  = 1'b0;
               gate_out_d = 1'b0;
               state_d    = IDLE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      full_d = (count_d == '0);
   end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed scenarios followed by randomized
// traffic, every cycle compared against a slot-array reference model.
module tb_parking_gate_controller;

   localparam int N    = 8;
   localparam int IW   = 3;
   localparam int GATE = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          entry_req = 1'b0;
   logic          exit_req = 1'b0;
   logic [IW-1:0] exit_slot = '0;
   logic          entry_ack, exit_ack, exit_err, gate_in_open, gate_out_open, full;
   logic [IW-1:0] assigned_slot;
   logic [N-1:0]  free_map;
   logic [IW:0]   free_count;

   int checks = 0;
   int errors = 0;

   // Reference model: per-slot occupancy and a gate-open countdown.
   bit            occ[N];
   int            open_left;
   bit            m_gin, m_gout, m_eack, m_xack, m_err;
   int            m_slot;

   parking_gate_controller #(.N_SLOTS(N), .IDX_W(IW), .GATE_CYCLES(GATE)) dut (
      .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
      .exit_slot(exit_slot), .entry_ack(entry_ack), .assigned_slot(assigned_slot),
      .exit_ack(exit_ack), .exit_err(exit_err), .gate_in_open(gate_in_open),
      .gate_out_open(gate_out_open), .free_map(free_map), .free_count(free_count),
      .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_free_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) if (!occ[i]) c++;
      return c;
   endfunction

   function automatic logic [N-1:0] model_map();
      logic [N-1:0] m = '0;
      for (int i = 0; i < N; i++) m[N-1-i] = !occ[i];
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) occ[i] = 1'b0;
      open_left = 0; m_gin = 0; m_gout = 0; m_eack = 0; m_xack = 0; m_err = 0; m_slot = 0;
   endtask

   task automatic model_edge(input bit er, input bit xr, input int xs);
      m_eack = 0; m_xack = 0; m_err = 0;
      if (open_left > 0) begin
         open_left--;
         if (open_left == 0) begin m_gin = 0; m_gout = 0; end
      end else if (xr) begin
         m_xack = 1;
         if (xs < N && occ[xs]) begin
            occ[xs] = 0; m_gout = 1; open_left = GATE;
         end else m_err = 1;
      end else if (er && model_free_cnt() > 0) begin
         for (int i = 0; i < N; i++)
            if (!occ[i]) begin occ[i] = 1; m_slot = i; break; end
         m_eack = 1; m_gin = 1; open_left = GATE;
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".entry_ack"}, 32'(entry_ack), 32'(m_eack));
      chk({ctx, ".exit_ack"}, 32'(exit_ack), 32'(m_xack));
      chk({ctx, ".exit_err"}, 32'(exit_err), 32'(m_err));
      chk({ctx, ".gate_in"}, 32'(gate_in_open), 32'(m_gin));
      chk({ctx, ".gate_out"}, 32'(gate_out_open), 32'(m_gout));
      chk({ctx, ".assigned"}, 32'(assigned_slot), 32'(m_slot));
      chk({ctx, ".free_map"}, 32'(free_map), 32'(model_map()));
      chk({ctx, ".free_count"}, 32'(free_count), 32'(model_free_cnt()));
      chk({ctx, ".full"}, 32'(full), 32'(model_free_cnt() == 0));
   endtask

   // One clock: drive at negedge, model the posedge, compare at next negedge.
   task automatic step(input bit er, input bit xr, input int xs, input string ctx);
      entry_req = er; exit_req = xr; exit_slot = IW'(xs);
      @(posedge clk);
      model_edge(er, xr, xs);
      @(negedge clk);
      check_all(ctx);
   endtask

   initial begin
      int acks;
      bit er, xr;
      int xs;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset.free_map", 32'(free_map), 32'hFF);
      chk("reset.free_count", 32'(free_count), 32'd8);
      chk("reset.full", 32'(full), 32'd0);
      chk("reset.gates", 32'({gate_in_open, gate_out_open}), 32'd0);
      chk("reset.assigned", 32'(assigned_slot), 32'd0);
      rst_n = 1'b1;

      step(1, 0, 0, "entry0");
      chk("entry0.slot", 32'(assigned_slot), 32'd0);
      chk("entry0.map", 32'(free_map), 32'h7F);
      for (int i = 0; i < GATE; i++) step(0, 0, 0, "entry0.open");
      chk("entry0.closed", 32'(gate_in_open), 32'd0);

      for (int k = 1; k < N; k++) begin
         step(1, 0, 0, "fill");
         for (int i = 0; i < GATE; i++) step(0, 0, 0, "fill.open");
      end
      step(0, 1, 2, "free2");
      for (int i = 0; i < GATE; i++) step(0, 0, 0, "free2.open");
      chk("preload.map", 32'(free_map), 32'h20);
      step(1, 0, 0, "firstfit");
      chk("firstfit.slot", 32'(assigned_slot), 32'd2);
      chk("firstfit.full", 32'(full), 32'd1);
      for (int i = 0; i < GATE; i++) step(0, 0, 0, "firstfit.open");

      acks = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, "blocked");
         if (entry_ack) acks++;
      end
      chk("blocked.acks", 32'(acks), 32'd0);

      step(1, 1, 5, "simul");
      chk("simul.exit_ack", 32'(exit_ack), 32'd1);
      chk("simul.map", 32'(free_map), 32'h04);
      for (int i = 0; i < GATE; i++) step(1, 0, 0, "simul.open");
      step(1, 0, 0, "simul.entry");
      chk("simul.entry_slot", 32'(assigned_slot), 32'd5);
      chk("simul.entry_full", 32'(full), 32'd1);
      for (int i = 0; i < GATE; i++) step(0, 0, 0, "simul.entry.open");

      step(0, 1, 1, "exit1");
      for (int i = 0; i < GATE; i++) step(0, 0, 0, "exit1.open");
      step(0, 1, 1, "badexit");
      chk("badexit.err", 32'(exit_err), 32'd1);
      chk("badexit.count", 32'(free_count), 32'd1);
      chk("badexit.gate", 32'(gate_out_open), 32'd0);
      step(0, 0, 0, "badexit.after");

      step(1, 0, 0, "midrst.grant");
      step(0, 0, 0, "midrst.c1");
      step(0, 0, 0, "midrst.c2");
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.gate_async", 32'(gate_in_open), 32'd0);
      chk("midrst.map_async", 32'(free_map), 32'hFF);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, "midrst.entry");
      chk("midrst.slot", 32'(assigned_slot), 32'd0);

      // Randomized traffic obeying the level request/ack handshake.
      er = 0; xr = 0; xs = 0;
      for (int n = 0; n < 400; n++) begin
         if (!er && ($urandom % 3) == 0) er = 1;
         if (!xr && ($urandom % 4) == 0) begin xr = 1; xs = int'($urandom % N); end
         step(er, xr, xs, "rand");
         if (m_eack) er = 0;
         if (m_xack) xr = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sequences the parking lot's entry and exit gates and owns the slot-occupancy map.
- On an entry request it allocates the first free slot, using the same priority order as the slot-number encoder: slot 0 is the MSB of the map.
- On an exit request it releases the named slot. Each grant opens the corresponding gate for a fixed time.
- Sits between the gate sensors/ticket units and the display/slot-number logic, which consume free_map, free_count and full.

Parameters:
- N_SLOTS, 8, number of parking slots.
- IDX_W, 3, slot index width; must satisfy 2**IDX_W >= N_SLOTS.
- GATE_CYCLES, 4, number of clock cycles a gate stays open per grant; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- entry_req  input  1  level request from the entry unit; held until entry_ack.
- exit_req  input  1  level request from the exit unit; held until exit_ack.
- exit_slot  input  IDX_W  slot being vacated; valid while exit_req is high.
- entry_ack  output  1  one-cycle pulse: entry granted.
- assigned_slot  output  IDX_W  slot allocated by the last entry grant; holds its value until the next grant.
- exit_ack  output  1  one-cycle pulse: exit request consumed.
- exit_err  output  1  one-cycle pulse, coincident with exit_ack: exit_slot was already free or out of range.
- gate_in_open  output  1  entry gate drive.
- gate_out_open  output  1  exit gate drive.
- free_map  output  N_SLOTS  1 = slot free; bit N_SLOTS-1 = slot 0.
- free_count  output  IDX_W+1  number of 1s in free_map.
- full  output  1  high when free_count == 0.

Behaviour:
- Reset (asynchronous, rst_n low), regardless of the current state:
  - free_map = all ones; free_count = N_SLOTS; full = 0.
  - All acks, exit_err and gate outputs = 0; assigned_slot = 0; state = IDLE; timer = 0.
  - A gate that is open closes immediately.
- FSM has three states: IDLE, ENTRY_OPEN, EXIT_OPEN. All outputs are registered.
- IDLE, evaluated at each rising edge in priority order:
  1. exit_req=1, exit_slot < N_SLOTS and the slot is occupied:
     - clear occupancy (set its free_map bit); free_count +1.
     - exit_ack=1; gate_out_open=1; timer=GATE_CYCLES-1; go to EXIT_OPEN.
  2. exit_req=1 and the slot is free or out of range:
     - exit_ack=1 and exit_err=1 for one cycle; map unchanged; stay in IDLE.
  3. entry_req=1 and full=0:
     - k = lowest free index, i.e. the most-significant 1 in free_map.
     - clear that free_map bit; free_count -1; assigned_slot=k.
     - entry_ack=1; gate_in_open=1; timer=GATE_CYCLES-1; go to ENTRY_OPEN.
  4. entry_req=1 and full=1: no ack; the request stays pending until a slot frees.
- Exit beats entry when both requests arrive on the same edge. The entry is served on a later IDLE edge.
- ENTRY_OPEN / EXIT_OPEN:
  - Requests are ignored.
  - timer decrements each edge. On the edge where timer==0, the gate output goes to 0 and the state returns to IDLE.
  - Each gate is therefore high for exactly GATE_CYCLES cycles.
  - The earliest next grant is GATE_CYCLES+1 edges after the previous grant.
- Requester handshake: req must be deasserted in the cycle after its ack. Holding req beyond the open window is treated as a new request.
- full and free_count update on the same edge as free_map.
- free_count never underflows: entry is blocked at 0. It never exceeds N_SLOTS: a double exit is flagged by exit_err and does not increment.
- Unused map positions (when N_SLOTS < 2**IDX_W) do not exist; those indices are out of range.

Test Plan:
- Reset: rst_n=0 then 1 -> free_map=8'hFF, free_count=8, full=0, both gates 0, assigned_slot=0.
- Entry from empty: entry_req=1 for one edge -> next cycle entry_ack=1, assigned_slot=0, free_map=8'h7F, free_count=7. gate_in_open is high for exactly 4 cycles, then IDLE.
- First-fit allocation: preload occupancy so free_map=8'h20 (only slot 2 free), then entry_req -> assigned_slot=3'b010, free_map=8'h00, full=1. A further entry_req gets no ack for 20 cycles.
- Simultaneous requests while full: entry_req and exit_req with exit_slot=5 on the same edge -> exit_ack first, free_map=8'h04, gate_out_open for 4 cycles. Then entry_ack with assigned_slot=5 and full=1 again.
- Bad exit: exit_req with exit_slot=1 while slot 1 is free -> exit_ack=1 and exit_err=1 for one cycle, free_map/free_count unchanged, no gate opens.
- Reset mid-operation: assert rst_n=0 two cycles into ENTRY_OPEN -> gate_in_open drops without waiting for a clock edge; after release, free_map=8'hFF and the next entry_req gets assigned_slot=0.
